// File: rtl/pack43_sched.sv
// Round-robin arbiter that lends a single 12-to-43-bit packer to NREQ requesters,
// one full word at a time, and returns each packed word tagged with its source ID.
module pack43_sched #(
    parameter int NREQ    = 2,
    parameter int BEATS   = 4,
    parameter int TIMEOUT = 16,
    parameter int IDW     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*12-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 pk_write_enable,
    output logic [11:0]          pk_data_in,
    input  logic                 pk_read_enable,
    input  logic                 pk_data_ready,
    input  logic [42:0]          pk_data_out,
    output logic                 out_valid,
    output logic [42:0]          out_data,
    output logic [IDW-1:0]       out_src,
    input  logic                 out_ready,
    output logic                 err_timeout
);

    localparam int BCW = $clog2(BEATS + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        WAIT_PACK = 2'd2,
        HOLD      = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [IDW-1:0]   rr_ptr_r;
    logic [IDW-1:0]   grant_r;
    logic [BCW-1:0]   beat_cnt_r;
    logic [TCW-1:0]   tmo_cnt_r;

    logic             found_hi_s;
    logic             found_lo_s;
    logic [IDW-1:0]   pick_hi_s;
    logic [IDW-1:0]   pick_lo_s;
    logic             found_s;
    logic [IDW-1:0]   pick_s;
    logic             sel_valid_s;
    logic [11:0]      sel_data_s;
    logic             xfer_s;
    logic             last_beat_s;
    logic             capture_s;
    logic             timeout_s;
    logic [IDW-1:0]   grant_next_s;

    // Round-robin search: prefer the lowest valid index at or above rr_ptr, else wrap to the lowest.
    always_comb begin
        found_hi_s = 1'b0;
        found_lo_s = 1'b0;
        pick_hi_s  = '0;
        pick_lo_s  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (req_valid[j] && !found_lo_s) begin
                found_lo_s = 1'b1;
                pick_lo_s  = IDW'(j);
            end else begin
                found_lo_s = found_lo_s;
            end
            if (req_valid[j] && !found_hi_s && (IDW'(j) >= rr_ptr_r)) begin
                found_hi_s = 1'b1;
                pick_hi_s  = IDW'(j);
            end else begin
                found_hi_s = found_hi_s;
            end
        end
        found_s = found_hi_s | found_lo_s;
        pick_s  = found_hi_s ? pick_hi_s : pick_lo_s;
    end

    // Granted-requester mux, ready generation and per-cycle event decode.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_data_s  = 12'h000;
        req_ready   = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (grant_r == IDW'(j)) begin
                sel_valid_s  = req_valid[j];
                sel_data_s   = req_data[12*j +: 12];
                req_ready[j] = (state_r == STREAM) && pk_read_enable && (beat_cnt_r < BCW'(BEATS));
            end else begin
                req_ready[j] = 1'b0;
            end
        end
        xfer_s       = sel_valid_s && (|req_ready);
        last_beat_s  = xfer_s && (beat_cnt_r == BCW'(BEATS - 1));
        // Counter 0 is the cycle of the final strobe, so a ready flag seen then is stale.
        capture_s    = (state_r == WAIT_PACK) && pk_data_ready && (tmo_cnt_r != TCW'(0));
        timeout_s    = (state_r == WAIT_PACK) && !capture_s && (tmo_cnt_r == TCW'(TIMEOUT - 1));
        grant_next_s = (grant_r == IDW'(NREQ - 1)) ? IDW'(0) : (grant_r + IDW'(1));
    end

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (found_s) state_nx_s = STREAM;
                else         state_nx_s = IDLE;
            end
            STREAM: begin
                if (last_beat_s) state_nx_s = WAIT_PACK;
                else             state_nx_s = STREAM;
            end
            WAIT_PACK: begin
                if (capture_s)      state_nx_s = HOLD;
                else if (timeout_s) state_nx_s = IDLE;
                else                state_nx_s = WAIT_PACK;
            end
            HOLD: begin
                if (out_ready) state_nx_s = IDLE;
                else           state_nx_s = HOLD;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_r <= IDLE;
        else      state_r <= state_nx_s;
    end

    // Grant, counters, packer drive and output word registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_r        <= '0;
            grant_r         <= '0;
            beat_cnt_r      <= '0;
            tmo_cnt_r       <= '0;
            pk_write_enable <= 1'b0;
            pk_data_in      <= 12'h000;
            out_valid       <= 1'b0;
            out_data        <= 43'h0;
            out_src         <= '0;
            err_timeout     <= 1'b0;
        end else begin
            pk_write_enable <= xfer_s;
            if (xfer_s) pk_data_in <= sel_data_s;
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        grant_r    <= pick_s;
                        beat_cnt_r <= '0;
                    end
                end
                STREAM: begin
                    if (xfer_s) begin
                        beat_cnt_r <= beat_cnt_r + BCW'(1);
                        tmo_cnt_r  <= '0;
                    end
                end
                WAIT_PACK: begin
                    tmo_cnt_r <= tmo_cnt_r + TCW'(1);
                    if (capture_s) begin
                        out_data  <= pk_data_out;
                        out_src   <= grant_r;
                        out_valid <= 1'b1;
                    end else if (timeout_s) begin
                        err_timeout <= 1'b1;
                        rr_ptr_r    <= grant_next_s;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        rr_ptr_r  <= grant_next_s;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pack43_sched.sv
// Directed bench for pack43_sched with queue-driven requesters and a simple packer model.
module tb_pack43_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid = 2'b00;
    logic [23:0] req_data = 24'h0;
    logic [1:0]  req_ready;
    logic        pk_write_enable;
    logic [11:0] pk_data_in;
    logic        pk_read_enable;
    logic        pk_data_ready = 1'b0;
    logic [42:0] pk_data_out = 43'h0;
    logic        out_valid;
    logic [42:0] out_data;
    logic [2:0]  out_src;
    logic        out_ready;
    logic        err_timeout;

    int checks = 0;
    int failures = 0;

    logic [11:0] q0[$];
    logic [11:0] q1[$];
    logic [1:0]  taken = 2'b00;
    int          xfer_cnt = 0;
    logic [45:0] outq[$];
    int          strobe_cnt = 0;
    int          dual_cnt = 0;
    logic [11:0] slog[$];
    logic        pk_clear = 1'b1;
    logic        pk_never = 1'b0;
    logic [11:0] pk_buf[4];
    int          pk_cnt = 0;

    always #5 clk = ~clk;

    pack43_sched #(.NREQ(2), .BEATS(4), .TIMEOUT(16), .IDW(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .pk_write_enable(pk_write_enable), .pk_data_in(pk_data_in),
        .pk_read_enable(pk_read_enable), .pk_data_ready(pk_data_ready), .pk_data_out(pk_data_out),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(out_ready),
        .err_timeout(err_timeout)
    );

    function automatic logic [42:0] pack4(input logic [11:0] b0, input logic [11:0] b1,
                                          input logic [11:0] b2, input logic [11:0] b3);
        return {b3[6:0], b2, b1, b0};
    endfunction

    // Edge monitor: handshakes as seen by the DUT at the rising edge.
    always @(posedge clk) begin
        taken <= req_valid & req_ready;
        if (|(req_valid & req_ready)) xfer_cnt <= xfer_cnt + 1;
        if (out_valid && out_ready) outq.push_back({out_src, out_data});
    end

    // Requester driver: retire accepted beats, present the next head of each queue.
    always @(negedge clk) begin
        if (taken[0] && q0.size() > 0) q0.delete(0);
        if (taken[1] && q1.size() > 0) q1.delete(0);
        req_valid[0]     = (q0.size() > 0);
        req_valid[1]     = (q1.size() > 0);
        req_data[11:0]   = (q0.size() > 0) ? q0[0] : 12'h000;
        req_data[23:12]  = (q1.size() > 0) ? q1[0] : 12'h000;
    end

    // Packer model: four strobed beats make a word; ready drops once the word is taken.
    always @(negedge clk) begin
        if (pk_clear) begin
            pk_cnt        = 0;
            pk_data_ready = 1'b0;
        end else begin
            if (out_valid) pk_data_ready = 1'b0;
            if (pk_write_enable) begin
                pk_buf[pk_cnt] = pk_data_in;
                pk_cnt++;
                if (pk_cnt == 4) begin
                    pk_cnt        = 0;
                    pk_data_out   = pack4(pk_buf[0], pk_buf[1], pk_buf[2], pk_buf[3]);
                    pk_data_ready = !pk_never;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        if (pk_write_enable) begin
            strobe_cnt++;
            slog.push_back(pk_data_in);
        end
        if (req_ready[0] && req_ready[1]) dual_cnt++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input int r, input logic [11:0] b0, input logic [11:0] b1,
                             input logic [11:0] b2, input logic [11:0] b3);
        if (r == 0) begin
            q0.push_back(b0); q0.push_back(b1); q0.push_back(b2); q0.push_back(b3);
        end else begin
            q1.push_back(b0); q1.push_back(b1); q1.push_back(b2); q1.push_back(b3);
        end
    endtask

    task automatic wait_outs(input int n, input int budget, input string tag);
        int k = 0;
        while (outq.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 64'(outq.size()), 64'(n));
    endtask

    initial begin
        int first, last, k, ws, n, ovs, sc, sc_start, base, stall_rdy, hold_bad;
        logic [42:0] exp_g;

        rst = 1'b0; out_ready = 1'b0; pk_read_enable = 1'b0;
        push_word(0, 12'h001, 12'h002, 12'h003, 12'h004);
        repeat (3) tick();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_pk_we", 64'(pk_write_enable), 64'd0);
        chk("rst_pk_data_in", 64'(pk_data_in), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_src", 64'(out_src), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);

        // Single requester, no stalls.
        rst = 1'b1; pk_clear = 1'b0; pk_read_enable = 1'b1; out_ready = 1'b1;
        slog.delete();
        first = -1; last = -1; k = 0;
        while (!out_valid && k < 40) begin
            tick();
            k++;
            if (pk_write_enable) begin
                if (first < 0) first = k;
                last = k;
            end
        end
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_data", 64'(out_data), 64'(pack4(12'h001, 12'h002, 12'h003, 12'h004)));
        chk("t1_out_src", 64'(out_src), 64'd0);
        chk("t1_strobes", 64'(strobe_cnt), 64'd4);
        chk("t1_consecutive", 64'(last - first), 64'd3);
        chk("t1_order", {16'h0, slog[0], slog[1], slog[2], slog[3]}, 64'h0000_0010_0200_3004);
        tick();
        chk("t1_ov_fall", 64'(out_valid), 64'd0);
        chk("t1_outq", 64'(outq.size()), 64'd1);

        // Both requesters valid; pointer now at 1 so grants go 1,0,1,0.
        push_word(0, 12'h101, 12'h102, 12'h103, 12'h104);
        push_word(1, 12'h201, 12'h202, 12'h203, 12'h204);
        push_word(0, 12'h301, 12'h302, 12'h303, 12'h304);
        push_word(1, 12'h401, 12'h402, 12'h403, 12'h404);
        wait_outs(5, 300, "t2_words");
        chk("t2_w1", 64'(outq[1]), 64'({3'd1, pack4(12'h201, 12'h202, 12'h203, 12'h204)}));
        chk("t2_w2", 64'(outq[2]), 64'({3'd0, pack4(12'h101, 12'h102, 12'h103, 12'h104)}));
        chk("t2_w3", 64'(outq[3]), 64'({3'd1, pack4(12'h401, 12'h402, 12'h403, 12'h404)}));
        chk("t2_w4", 64'(outq[4]), 64'({3'd0, pack4(12'h301, 12'h302, 12'h303, 12'h304)}));
        chk("t2_dual_ready", 64'(dual_cnt), 64'd0);

        // Packer back-pressure for 5 cycles after beat 2.
        sc_start = strobe_cnt; base = xfer_cnt; k = 0;
        push_word(1, 12'h0A1, 12'h0A2, 12'h0A3, 12'h0A4);
        while (xfer_cnt < base + 2 && k < 30) begin
            tick();
            k++;
        end
        chk("t3_two_beats", 64'(xfer_cnt - base), 64'd2);
        pk_read_enable = 1'b0;
        sc = strobe_cnt; stall_rdy = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (req_ready != 2'b00) stall_rdy++;
        end
        chk("t3_stall_ready", 64'(stall_rdy), 64'd0);
        chk("t3_stall_strobes", 64'(strobe_cnt - sc), 64'd0);
        pk_read_enable = 1'b1;
        wait_outs(6, 60, "t3_word");
        chk("t3_total_strobes", 64'(strobe_cnt - sc_start), 64'd4);
        chk("t3_data", 64'(outq[5]), 64'({3'd1, pack4(12'h0A1, 12'h0A2, 12'h0A3, 12'h0A4)}));

        // Packer never ready: timeout, then the other requester is served.
        pk_never = 1'b1;
        push_word(0, 12'h0B1, 12'h0B2, 12'h0B3, 12'h0B4);
        push_word(1, 12'h0F1, 12'h0F2, 12'h0F3, 12'h0F4);
        ws = 0; k = 0;
        while (ws < 4 && k < 40) begin
            tick();
            k++;
            if (pk_write_enable) ws++;
        end
        chk("t4_strobes", 64'(ws), 64'd4);
        n = 0; ovs = 0;
        while (!err_timeout && n < 40) begin
            tick();
            n++;
            if (out_valid) ovs++;
        end
        chk("t4_timeout_latency", 64'(n), 64'd16);
        chk("t4_err", 64'(err_timeout), 64'd1);
        chk("t4_no_out_valid", 64'(ovs), 64'd0);
        chk("t4_no_word", 64'(outq.size()), 64'd6);
        pk_never = 1'b0;
        wait_outs(7, 60, "t4_next_word");
        chk("t4_next_src", 64'(outq[6]), 64'({3'd1, pack4(12'h0F1, 12'h0F2, 12'h0F3, 12'h0F4)}));
        chk("t4_err_sticky", 64'(err_timeout), 64'd1);

        // Downstream stall for 10 cycles.
        out_ready = 1'b0;
        exp_g = pack4(12'h0C1, 12'h0C2, 12'h0C3, 12'h0C4);
        push_word(0, 12'h0C1, 12'h0C2, 12'h0C3, 12'h0C4);
        push_word(1, 12'h0E1, 12'h0E2, 12'h0E3, 12'h0E4);
        k = 0;
        while (!out_valid && k < 40) begin
            tick();
            k++;
        end
        chk("t5_out_valid", 64'(out_valid), 64'd1);
        sc = strobe_cnt; hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!out_valid || out_data !== exp_g || out_src !== 3'd0) hold_bad++;
        end
        chk("t5_hold_stable", 64'(hold_bad), 64'd0);
        chk("t5_no_strobe", 64'(strobe_cnt - sc), 64'd0);
        out_ready = 1'b1;
        tick();
        chk("t5_ov_fall", 64'(out_valid), 64'd0);
        chk("t5_word", 64'(outq[7]), 64'({3'd0, exp_g}));
        wait_outs(9, 60, "t5_next_word");
        chk("t5_next", 64'(outq[8]), 64'({3'd1, pack4(12'h0E1, 12'h0E2, 12'h0E3, 12'h0E4)}));

        // Reset during beat 3, then a fresh word.
        base = xfer_cnt; k = 0;
        push_word(0, 12'h0D1, 12'h0D2, 12'h0D3, 12'h0D4);
        while (xfer_cnt < base + 3 && k < 30) begin
            tick();
            k++;
        end
        chk("t6_three_beats", 64'(xfer_cnt - base), 64'd3);
        rst = 1'b0; pk_clear = 1'b1;
        q0.delete(); q1.delete();
        tick();
        chk("t6_req_ready", 64'(req_ready), 64'd0);
        chk("t6_pk_we", 64'(pk_write_enable), 64'd0);
        chk("t6_pk_data_in", 64'(pk_data_in), 64'd0);
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_out_data", 64'(out_data), 64'd0);
        chk("t6_out_src", 64'(out_src), 64'd0);
        chk("t6_err", 64'(err_timeout), 64'd0);
        tick();
        rst = 1'b1; pk_clear = 1'b0;
        push_word(0, 12'h051, 12'h052, 12'h053, 12'h054);
        wait_outs(10, 60, "t6_fresh_word");
        chk("t6_fresh", 64'(outq[9]), 64'({3'd0, pack4(12'h051, 12'h052, 12'h053, 12'h054)}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the directed sequence ended");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pack43_sched.md
Name: pack43_sched

Overview:
- Round-robin scheduler that shares one 12-bit-to-43-bit packing memory between NREQ 12-bit requester streams.
- Grants one requester at a time for a full word of BEATS beats.
- Drives the packer's write_enable/data_in, honours its read_enable back-pressure, and waits for data_ready.
- Returns the packed 43-bit word with its source ID on a valid/ready output port.
- Sits between the per-channel input FIFOs and the 43-bit downstream consumer.

Parameters:
NREQ, 2, number of requesters (2..8)
BEATS, 4, 12-bit beats per packed word
TIMEOUT, 16, max cycles waiting for packer data_ready before abort
IDW, 3, width of source ID (ceil(log2(NREQ)), min 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
req_valid  in  NREQ  requester i has a beat
req_data  in  NREQ*12  beat of requester i at bits [12i+11:12i]
req_ready  out  NREQ  beat of requester i accepted this cycle when valid
pk_write_enable  out  1  write strobe to packer
pk_data_in  out  12  beat to packer
pk_read_enable  in  1  packer can accept a beat
pk_data_ready  in  1  packer has a full word
pk_data_out  in  43  packed word from packer
out_valid  out  1  packed word available
out_data  out  43  packed word
out_src  out  IDW  requester that produced out_data
out_ready  in  1  downstream accepts word
err_timeout  out  1  sticky: a packer wait timed out

Behaviour:
- Reset (rst==0 at a clk edge):
  - State=IDLE, rr_ptr=0, beat_cnt=0, timeout counter=0.
  - All outputs 0: req_ready, pk_write_enable, pk_data_in, out_valid, out_data, out_src, err_timeout.
  - Reset mid-operation abandons the current word with no output; the bench must also reset the packer.
- States: IDLE, STREAM, WAIT_PACK, HOLD.
- IDLE:
  - Search requesters starting at rr_ptr, ascending and wrapping at NREQ.
  - The first one with req_valid=1 becomes grant.
  - Next cycle: state=STREAM, beat_cnt=0.
  - No valid requester: stay in IDLE.
- STREAM:
  - req_ready[grant] = pk_read_enable && beat_cnt<BEATS. This is combinational; all other req_ready bits are 0.
  - A transfer happens when req_valid[grant] && req_ready[grant].
  - On a transfer, the next cycle drives pk_write_enable=1 and pk_data_in=that beat (1-cycle registered latency), and beat_cnt increments.
  - Otherwise pk_write_enable=0 and pk_data_in holds its last value.
  - When the BEATS-th transfer occurs, go to WAIT_PACK. The final write strobe occurs in the first WAIT_PACK cycle.
  - Grant is locked for the whole word. Other requesters are ignored even if the granted requester stalls.
- WAIT_PACK:
  - Counter increments each cycle.
  - First cycle with pk_data_ready=1 and the counter ≥1 (i.e. after the final strobe): capture out_data=pk_data_out and out_src=grant, set out_valid=1, go to HOLD.
  - Counter reaches TIMEOUT without data_ready: set err_timeout=1 (sticky until reset), drop the word, set rr_ptr=(grant+1)%NREQ, go to IDLE.
- HOLD:
  - out_valid=1; out_data and out_src stable until out_ready=1.
  - On the handshake cycle: next cycle out_valid=0, rr_ptr=(grant+1)%NREQ, state=IDLE.
  - The new grant can start at the earliest the cycle after returning to IDLE. There are no back-to-back overlapping words.
- Packer data_ready held high over several cycles is captured only once per word.
- pk_read_enable dropping mid-word stalls STREAM with no loss and no duplication.
- req_valid going low mid-word is legal and stalls STREAM.
- Packed word width: only pk_data_out[42:0] is forwarded unchanged. No arithmetic is performed on the data.

Test Plan:
- Single requester, no stalls. req0 sends 0x001, 0x002, 0x003, 0x004 with out_ready=1 and packer model → four pk_write_enable pulses on consecutive cycles; out_valid with out_data=packer word and out_src=0; then IDLE.
- Both requesters continuously valid, 3 words → grant order 0,1,0; out_src sequence 0,1,0; req_ready never high for both in the same cycle.
- pk_read_enable=0 for 5 cycles after beat 2 → no req_ready and no write strobes for those 5 cycles; exactly 4 strobes total; data order preserved.
- Packer never asserts data_ready → after TIMEOUT=16 cycles in WAIT_PACK, err_timeout=1 and stays 1; out_valid never asserted; next word is granted to the other requester.
- out_ready held 0 for 10 cycles → out_valid, out_data and out_src stable throughout; no new pk_write_enable; after out_ready=1, out_valid falls next cycle.
- rst=0 asserted during beat 3 → all outputs 0 on the next edge; after release, a fresh word from req0 completes correctly.
